// File: rtl/ysyx_22050710_ifu.sv
// ysyx_22050710_ifu: instruction fetch unit with a REQ/WAIT/HOLD fetch FSM.
// Optional perf counters enabled by defining YSYX_22050710_IFU_PERF_EN.
module ysyx_22050710_ifu #(
  parameter int              ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h80000000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_imem_req_valid,
  input  logic              i_imem_req_ready,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_resp_valid,
  input  logic [63:0]       i_imem_rdata,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic [31:0]       o_inst,
  output logic [ADDR_W-1:0] o_pc,
`ifdef YSYX_22050710_IFU_PERF_EN
  output logic [63:0]       o_fetch_cnt,
  output logic [63:0]       o_stall_cnt,
`endif
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [31:0]       inst_q, inst_d;

  logic [ADDR_W-1:0] redir_pc;
  logic [31:0]       resp_word;

  assign redir_pc  = i_redirect_pc
                   & ~{{(ADDR_W-2){1'b0}}, 2'b11};
  assign resp_word = pc_q[2] ? i_imem_rdata[63:32]
                             : i_imem_rdata[31:0];

  // State, PC, drop flag and instruction buffer registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      inst_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
    end
  end

  // Next-state: fetch sequencing, redirect and stale-response dropping
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    unique case (state_q)
      S_REQ: begin
        if (i_imem_req_ready) begin
          state_d = S_WAIT;
          if (i_redirect_valid) begin
            pc_d   = redir_pc;
            drop_d = 1'b1;
          end
        end else if (i_redirect_valid) begin
          pc_d = redir_pc;
        end
      end
      S_WAIT: begin
        if (i_redirect_valid) begin
          pc_d = redir_pc;
        end
        if (i_imem_resp_valid) begin
          drop_d = 1'b0;
          if (drop_q || i_redirect_valid) begin
            state_d = S_REQ;
          end else begin
            inst_d  = resp_word;
            state_d = S_HOLD;
          end
        end else if (i_redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (i_redirect_valid) begin
          pc_d    = redir_pc;
          state_d = S_REQ;
        end else if (i_inst_ready) begin
          pc_d    = pc_q + ADDR_W'(4);
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // Outputs: request is suppressed while reset is held
  always_comb begin
    o_imem_req_valid = (state_q == S_REQ) && !i_rst;
    o_imem_addr      = {pc_q[ADDR_W-1:3], 3'b000};
    o_inst_valid     = (state_q == S_HOLD);
    o_inst           = inst_q;
    o_pc             = pc_q;
  end

`ifdef YSYX_22050710_IFU_PERF_EN
  logic [63:0] fetch_cnt_q, fetch_cnt_d;
  logic [63:0] stall_cnt_q, stall_cnt_d;

  // Perf counters: consumed fetches and stalled cycles
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (state_q == S_HOLD && i_inst_ready
        && !i_redirect_valid) begin
      fetch_cnt_d = fetch_cnt_q + 64'd1;
    end
    if (state_q == S_WAIT
        || (state_q == S_HOLD && !i_inst_ready)) begin
      stall_cnt_d = stall_cnt_q + 64'd1;
    end
  end

  // Perf counter registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_cnt_q <= 64'd0;
      stall_cnt_q <= 64'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_fetch_cnt = fetch_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_22050710_ifu.sv
// tb_ysyx_22050710_ifu: directed self-checking bench for the fetch unit.
// Perf counter checks compile in with YSYX_22050710_IFU_PERF_EN.
module tb_ysyx_22050710_ifu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] addr;
  logic        resp_valid;
  logic [63:0] rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        redir_valid;
  logic [63:0] redir_pc;
`ifdef YSYX_22050710_IFU_PERF_EN
  logic [63:0] fetch_cnt;
  logic [63:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ysyx_22050710_ifu dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .o_imem_req_valid  (req_valid),
    .i_imem_req_ready  (req_ready),
    .o_imem_addr       (addr),
    .i_imem_resp_valid (resp_valid),
    .i_imem_rdata      (rdata),
    .o_inst_valid      (inst_valid),
    .i_inst_ready      (inst_ready),
    .o_inst            (inst),
    .o_pc              (pc),
`ifdef YSYX_22050710_IFU_PERF_EN
    .o_fetch_cnt       (fetch_cnt),
    .o_stall_cnt       (stall_cnt),
`endif
    .i_redirect_valid  (redir_valid),
    .i_redirect_pc     (redir_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait (bounded) for a request at a negedge
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One full zero-wait fetch: REQ -> WAIT -> HOLD -> consume
  task automatic fetch_one(input  logic [63:0] d,
                           output logic [63:0] a,
                           output logic [31:0] w,
                           output logic [63:0] p,
                           output bit          ok);
    bit got;
    ok = 1'b0;
    a  = 'x;
    w  = 'x;
    p  = 'x;
    wait_req(got);
    if (got) begin
      a = addr;
      req_ready = 1'b1;
      @(negedge clk);
      req_ready  = 1'b0;
      resp_valid = 1'b1;
      rdata      = d;
      @(negedge clk);
      resp_valid = 1'b0;
      if (inst_valid === 1'b1) begin
        w = inst;
        p = pc;
        ok = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_ready = 0; resp_valid = 0; rdata = '0;
    inst_ready = 0; redir_valid = 0; redir_pc = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_valid !== 1'b0 || inst_valid !== 1'b0
        || inst !== 32'd0 || pc !== 64'h80000000) begin
      errors++;
      $display("FAIL reset: rv=%b iv=%b inst=%h pc=%h",
               req_valid, inst_valid, inst, pc);
    end
`ifdef YSYX_22050710_IFU_PERF_EN
    checks++;
    if (fetch_cnt !== 64'd0 || stall_cnt !== 64'd0) begin
      errors++;
      $display("FAIL reset_perf: f=%0d s=%0d", fetch_cnt, stall_cnt);
    end
`endif
    rst = 1'b0;
    #1;
    checks++;
    if (req_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: req_valid=%b want 1", req_valid);
    end
  endtask

  task automatic test_basic();
    logic [63:0] d [3];
    logic [63:0] ea [3];
    logic [31:0] ew [3];
    logic [63:0] ep [3];
    logic [63:0] a, p;
    logic [31:0] w;
    bit ok;
    d[0] = 64'h00100073_00000513; ea[0] = 64'h80000000;
    ew[0] = 32'h00000513;         ep[0] = 64'h80000000;
    d[1] = 64'h00100073_00000513; ea[1] = 64'h80000000;
    ew[1] = 32'h00100073;         ep[1] = 64'h80000004;
    d[2] = 64'h55555555_0badf00d; ea[2] = 64'h80000008;
    ew[2] = 32'h0badf00d;         ep[2] = 64'h80000008;
    for (int i = 0; i < 3; i++) begin
      fetch_one(d[i], a, w, p, ok);
      checks++;
      if (!ok || a !== ea[i] || w !== ew[i] || p !== ep[i]) begin
        errors++;
        $display("FAIL basic[%0d]: ok=%b addr=%h inst=%h pc=%h want %h %h %h",
                 i, ok, a, w, p, ea[i], ew[i], ep[i]);
      end
    end
  endtask

  task automatic test_hold_stall();
    bit ok;
    wait_req(ok);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    resp_valid = 1'b1;
    rdata = 64'haaaabbbb_11112222;
    @(negedge clk);
    resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (!ok || inst_valid !== 1'b1 || req_valid !== 1'b0
          || inst !== 32'haaaabbbb || pc !== 64'h8000000c) begin
        errors++;
        $display("FAIL hold[%0d]: iv=%b rv=%b inst=%h pc=%h",
                 i, inst_valid, req_valid, inst, pc);
      end
      @(negedge clk);
    end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || req_valid !== 1'b1
        || pc !== 64'h80000010 || addr !== 64'h80000010) begin
      errors++;
      $display("FAIL hold_release: iv=%b rv=%b pc=%h addr=%h want pc 80000010",
               inst_valid, req_valid, pc, addr);
    end
  endtask

  task automatic test_redirect_wait();
    logic [63:0] a, p;
    logic [31:0] w;
    bit ok;
    wait_req(ok);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    redir_valid = 1'b1;
    redir_pc = 64'h80001002;
    @(negedge clk);
    redir_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (inst_valid !== 1'b0 || req_valid !== 1'b0) begin
        errors++;
        $display("FAIL redir_wait_idle[%0d]: iv=%b rv=%b want 0 0",
                 i, inst_valid, req_valid);
      end
      @(negedge clk);
    end
    resp_valid = 1'b1;
    rdata = 64'hffffffff_eeeeeeee;
    @(negedge clk);
    resp_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || req_valid !== 1'b1
        || addr !== 64'h80001000 || pc !== 64'h80001000) begin
      errors++;
      $display("FAIL redir_wait_drop: iv=%b rv=%b addr=%h pc=%h want 0 1 80001000",
               inst_valid, req_valid, addr, pc);
    end
    fetch_one(64'h12345678_9abcdef0, a, w, p, ok);
    checks++;
    if (!ok || a !== 64'h80001000 || w !== 32'h9abcdef0
        || p !== 64'h80001000) begin
      errors++;
      $display("FAIL redir_wait_fetch: ok=%b addr=%h inst=%h pc=%h",
               ok, a, w, p);
    end
  endtask

  task automatic test_redirect_hold();
    bit ok;
    wait_req(ok);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    resp_valid = 1'b1;
    rdata = 64'hdeadbeef_cafef00d;
    @(negedge clk);
    resp_valid = 1'b0;
    checks++;
    if (!ok || inst_valid !== 1'b1 || inst !== 32'hdeadbeef
        || pc !== 64'h80001004) begin
      errors++;
      $display("FAIL redir_hold_pre: iv=%b inst=%h pc=%h want 1 deadbeef 80001004",
               inst_valid, inst, pc);
    end
    inst_ready = 1'b1;
    redir_valid = 1'b1;
    redir_pc = 64'h80000100;
    @(negedge clk);
    inst_ready = 1'b0;
    redir_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || req_valid !== 1'b1
        || addr !== 64'h80000100 || pc !== 64'h80000100) begin
      errors++;
      $display("FAIL redir_hold: iv=%b rv=%b addr=%h pc=%h want 80000100",
               inst_valid, req_valid, addr, pc);
    end
`ifdef YSYX_22050710_IFU_PERF_EN
    checks++;
    if (fetch_cnt !== 64'd5) begin
      errors++;
      $display("FAIL redir_hold_perf: fetch_cnt=%0d want 5", fetch_cnt);
    end
`endif
  endtask

  task automatic test_wrap();
    logic [63:0] a, p;
    logic [31:0] w;
    bit ok;
    redir_valid = 1'b1;
    redir_pc = 64'hffffffff_ffffffff;
    @(negedge clk);
    redir_valid = 1'b0;
    checks++;
    if (req_valid !== 1'b1 || addr !== 64'hffffffff_fffffff8
        || pc !== 64'hffffffff_fffffffc) begin
      errors++;
      $display("FAIL wrap_redir: rv=%b addr=%h pc=%h", req_valid, addr, pc);
    end
    fetch_one(64'h00000013_00000093, a, w, p, ok);
    checks++;
    if (!ok || a !== 64'hffffffff_fffffff8 || w !== 32'h00000013
        || p !== 64'hffffffff_fffffffc) begin
      errors++;
      $display("FAIL wrap_top: ok=%b addr=%h inst=%h pc=%h", ok, a, w, p);
    end
    fetch_one(64'h11111111_22222222, a, w, p, ok);
    checks++;
    if (!ok || a !== 64'd0 || w !== 32'h22222222 || p !== 64'd0) begin
      errors++;
      $display("FAIL wrap_zero: ok=%b addr=%h inst=%h pc=%h want 0 22222222 0",
               ok, a, w, p);
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] a, p;
    logic [31:0] w;
    bit ok;
    wait_req(ok);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (!ok || req_valid !== 1'b0 || inst_valid !== 1'b0
        || inst !== 32'd0 || pc !== 64'h80000000) begin
      errors++;
      $display("FAIL async_reset: rv=%b iv=%b inst=%h pc=%h",
               req_valid, inst_valid, inst, pc);
    end
`ifdef YSYX_22050710_IFU_PERF_EN
    checks++;
    if (fetch_cnt !== 64'd0 || stall_cnt !== 64'd0) begin
      errors++;
      $display("FAIL async_reset_perf: f=%0d s=%0d", fetch_cnt, stall_cnt);
    end
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fetch_one(64'h00100073_00000513, a, w, p, ok);
    checks++;
    if (!ok || a !== 64'h80000000 || w !== 32'h00000513
        || p !== 64'h80000000) begin
      errors++;
      $display("FAIL async_reset_fetch: ok=%b addr=%h inst=%h pc=%h",
               ok, a, w, p);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
